// File: rtl/clock_pkg.sv
// clock_pkg: shared field encodings, digit limits and FSM states for the digital clock
package clock_pkg;
    localparam logic [1:0] SEL_MIN  = 2'd0;
    localparam logic [1:0] SEL_HOUR = 2'd1;
    localparam logic [1:0] SEL_DAY  = 2'd2;
    localparam logic [2:0] DAY_MIN = 3'd1;
    localparam logic [2:0] DAY_MAX = 3'd7;
    localparam logic [3:0] BCD_MAX_ONES = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;
    localparam logic [3:0] BCD_MAX_HOUR = 4'd2;
    localparam logic [3:0] HOUR_MAX_H = 4'd2;
    localparam logic [3:0] HOUR_MAX_L = 4'd3;
    typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: single BCD digit wrapping MAX->0 with a combinational carry on the wrap
module bcd_digit_counter #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] count,
    output logic       carry
);
    assign carry = inc && count == MAX;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= carry ? '0 : count + 4'd1;
endmodule

// File: rtl/time_base_bcd.sv
// time_base_bcd: one-second prescaler and BCD seconds/minutes/hours/day-of-week with manual set mode
module time_base_bcd
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       set_inc,
    output logic [3:0] sec_l,
    output logic [3:0] sec_h,
    output logic [3:0] min_l,
    output logic [3:0] min_h,
    output logic [3:0] hour_l,
    output logic [3:0] hour_h,
    output logic [2:0] day,
    output logic       sec_tick
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);
    state_t state;
    logic [PW-1:0] presc;
    logic enter_set, tick, set_step, counting;
    logic sec_l_c, sec_h_c, min_l_c, min_h_c;
    logic hour_wrap, hour_inc, day_inc;
    // The SET request wins over a coincident second advance
    assign counting  = state == RUN && !set_en;
    assign enter_set = state == RUN && set_en;
    assign tick      = counting && presc == LAST;
    assign set_step  = state == SET && set_inc;
    assign hour_wrap = hour_h == HOUR_MAX_H && hour_l == HOUR_MAX_L;
    assign hour_inc  = (tick && min_h_c) || (set_step && set_sel == SEL_HOUR);
    assign day_inc   = (tick && min_h_c && hour_wrap) || (set_step && set_sel == SEL_DAY);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= RUN;
            presc    <= '0;
            sec_tick <= 1'b0;
        end else begin
            state    <= set_en ? SET : RUN;
            presc    <= (counting && !tick) ? presc + 1'b1 : '0;
            sec_tick <= tick;
        end
    bcd_digit_counter #(.MAX(BCD_MAX_ONES)) u_sec_l (
        .clk(clk), .rst_n(rst_n), .inc(tick), .clr(enter_set), .count(sec_l), .carry(sec_l_c)
    );
    bcd_digit_counter #(.MAX(BCD_MAX_TENS)) u_sec_h (
        .clk(clk), .rst_n(rst_n), .inc(sec_l_c), .clr(enter_set), .count(sec_h), .carry(sec_h_c)
    );
    bcd_digit_counter #(.MAX(BCD_MAX_ONES)) u_min_l (
        .clk(clk), .rst_n(rst_n), .inc(sec_h_c || (set_step && set_sel == SEL_MIN)),
        .clr(1'b0), .count(min_l), .carry(min_l_c)
    );
    bcd_digit_counter #(.MAX(BCD_MAX_TENS)) u_min_h (
        .clk(clk), .rst_n(rst_n), .inc(min_l_c), .clr(1'b0), .count(min_h), .carry(min_h_c)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hour_h <= '0;
            hour_l <= '0;
        end else if (hour_inc) begin
            hour_h <= hour_wrap ? '0 : (hour_l == BCD_MAX_ONES ? hour_h + 4'd1 : hour_h);
            hour_l <= (hour_wrap || hour_l == BCD_MAX_ONES) ? '0 : hour_l + 4'd1;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            day <= DAY_MIN;
        else if (day_inc)
            day <= day == DAY_MAX ? DAY_MIN : day + 3'd1;
endmodule

// File: tb/tb_time_base_bcd.sv
// tb_time_base_bcd: scoreboard bench against a seconds-of-week reference model
module tb_time_base_bcd;
    localparam int T = 4;
    localparam int WEEK = 7 * 86400;
    logic clk = 1'b0, rst_n = 1'b1, set_en = 1'b0, set_inc = 1'b0;
    logic [1:0] set_sel = 2'd0;
    logic [3:0] sec_l, sec_h, min_l, min_h, hour_l, hour_h;
    logic [2:0] day;
    logic sec_tick;
    logic [27:0] got;
    logic [27:0] exp_q[$];
    int checks = 0, errors = 0, cyc = 0;
    int wk = 0, cnt = 0;
    bit mset = 1'b0, mtick = 1'b0;

    time_base_bcd #(.TICKS_PER_SEC(T)) dut (
        .clk(clk), .rst_n(rst_n), .set_en(set_en), .set_sel(set_sel), .set_inc(set_inc),
        .sec_l(sec_l), .sec_h(sec_h), .min_l(min_l), .min_h(min_h),
        .hour_l(hour_l), .hour_h(hour_h), .day(day), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;
    // Hex view reads hhmmss followed by one nibble of {day, tick}
    assign got = {hour_h, hour_l, min_h, min_l, sec_h, sec_l, day, sec_tick};

    function automatic logic [27:0] expect_vec();
        int s, m, h, d;
        s = wk % 60;
        m = (wk / 60) % 60;
        h = (wk / 3600) % 24;
        d = wk / 86400 + 1;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 3'(d), mtick};
    endfunction

    task automatic check(input logic [27:0] e, input string what);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s cyc %0d got %h exp %h", what, cyc, got, e);
        end
    endtask

    task automatic model_reset();
        wk = 0;
        cnt = 0;
        mset = 1'b0;
        mtick = 1'b0;
    endtask

    task automatic model_edge(input bit en, input logic [1:0] sel, input bit inc);
        int d, h, m;
        mtick = 1'b0;
        if (!rst_n)
            model_reset();
        else if (!mset) begin
            if (en) begin
                mset = 1'b1;
                cnt = 0;
                wk = wk - wk % 60;
            end else begin
                cnt = cnt + 1;
                if (cnt == T) begin
                    cnt = 0;
                    mtick = 1'b1;
                    wk = (wk + 1) % WEEK;
                end
            end
        end else begin
            if (inc) begin
                d = wk / 86400;
                h = (wk / 3600) % 24;
                m = (wk / 60) % 60;
                if (sel == 2'd0) m = (m + 1) % 60;
                else if (sel == 2'd1) h = (h + 1) % 24;
                else if (sel == 2'd2) d = (d + 1) % 7;
                wk = d * 86400 + h * 3600 + m * 60;
            end
            if (!en) begin
                mset = 1'b0;
                cnt = 0;
            end
        end
    endtask

    task automatic cycle(input bit en, input logic [1:0] sel, input bit inc);
        set_en = en;
        set_sel = sel;
        set_inc = inc;
        @(posedge clk);
        model_edge(en, sel, inc);
        exp_q.push_back(expect_vec());
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'($urandom_range(3)), $urandom_range(2) == 0);
    endtask

    task automatic pulses(input logic [1:0] sel, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, sel, 1'b1);
            cycle(1'b1, sel, 1'b0);
        end
    endtask

    task automatic async_reset();
        #1 rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1 check(expect_vec(), "async_reset");
        repeat (2) cycle(1'b0, 2'd0, 1'b0);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk)
        if (exp_q.size() != 0) check(exp_q.pop_front(), "outputs");

    initial begin
        bit ren;
        ren = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check(expect_vec(), "reset");
        repeat (3) cycle(1'b0, 2'd0, 1'b0);
        #1 rst_n = 1'b1;
        run(24);
        cycle(1'b1, 2'd0, 1'b1);
        pulses(2'd1, 23);
        pulses(2'd0, 59);
        pulses(2'd2, 6);
        cycle(1'b0, 2'd0, 1'b0);
        run(240);
        cycle(1'b1, 2'd0, 1'b0);
        pulses(2'd1, 12);
        pulses(2'd0, 34);
        cycle(1'b0, 2'd0, 1'b0);
        run(27 * T);
        cycle(1'b1, 2'd0, 1'b0);
        pulses(2'd0, 26);
        pulses(2'd1, 12);
        pulses(2'd2, 5);
        pulses(2'd2, 3);
        pulses(2'd3, 5);
        for (int i = 0; i < 40; i++) cycle(1'b1, 2'($urandom_range(3)), 1'b0);
        cycle(1'b0, 2'd0, 1'b0);
        run(8);
        cycle(1'b1, 2'd0, 1'b0);
        pulses(2'd1, 5);
        pulses(2'd0, 17);
        cycle(1'b0, 2'd0, 1'b0);
        run(42 * T + 2);
        async_reset();
        run(8);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) ren = !ren;
            cycle(ren, 2'($urandom_range(3)), $urandom_range(2) == 0);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
